// File: rtl/maxi_full_garin_if.sv
// AXI4 full bus bundle between the burst write/read-back master and its slave.
interface maxi_full_garin_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 6
);
  logic                          M_AXI_AWID;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [7:0]                    M_AXI_AWLEN;
  logic [2:0]                    M_AXI_AWSIZE;
  logic [1:0]                    M_AXI_AWBURST;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [31:0]                   M_AXI_WDATA;
  logic [3:0]                    M_AXI_WSTRB;
  logic                          M_AXI_WLAST;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;
  logic                          M_AXI_ARID;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [7:0]                    M_AXI_ARLEN;
  logic [2:0]                    M_AXI_ARSIZE;
  logic [1:0]                    M_AXI_ARBURST;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [31:0]                   M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RLAST;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  modport master (
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/maxi_full_garin.sv
// AXI4 full master: writes one INCR burst of counting data, reads it back and
// compares, raising a sticky ERROR on any bad response or data mismatch.
module maxi_full_garin #(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = {C_M_AXI_ADDR_WIDTH{1'b0}}
) (
  input  logic M_AXI_ACLK,
  input  logic M_AXI_ARESETN,
  input  logic INIT_AXI_TXN,
  output logic TXN_DONE,
  output logic ERROR,
  maxi_full_garin_if.master m_axi
);

  localparam int         DW       = C_M_AXI_DATA_WIDTH;
  localparam logic [4:0] LAST_IDX = 5'(C_M_AXI_BURST_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_r, state_nxt;
  logic            init_q_r;
  logic            awvalid_r, awvalid_nxt;
  logic            wvalid_r, wvalid_nxt;
  logic            wlast_r, wlast_nxt;
  logic [DW-1:0]   wdata_r, wdata_nxt;
  logic [4:0]      wcnt_r, wcnt_nxt;
  logic            aw_done_r, aw_done_nxt;
  logic            w_done_r, w_done_nxt;
  logic            bready_r, bready_nxt;
  logic            arvalid_r, arvalid_nxt;
  logic            rready_r, rready_nxt;
  logic [4:0]      rcnt_r, rcnt_nxt;
  logic            txn_done_r, txn_done_nxt;
  logic            error_r, error_nxt;

  logic            start_s;
  logic            aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic            beat_bad_s;

  assign start_s = INIT_AXI_TXN & ~init_q_r;
  assign aw_hs_s = awvalid_r & m_axi.M_AXI_AWREADY;
  assign w_hs_s  = wvalid_r & m_axi.M_AXI_WREADY;
  assign b_hs_s  = bready_r & m_axi.M_AXI_BVALID;
  assign ar_hs_s = arvalid_r & m_axi.M_AXI_ARREADY;
  assign r_hs_s  = rready_r & m_axi.M_AXI_RVALID;

  // A read beat is bad on wrong data, a non-OKAY response, or RLAST on the wrong beat.
  assign beat_bad_s = (m_axi.M_AXI_RDATA != {{(DW-5){1'b0}}, rcnt_r + 5'd1}) |
                      (m_axi.M_AXI_RRESP != 2'b00) |
                      (m_axi.M_AXI_RLAST != (rcnt_r == LAST_IDX));

  // Next-state and next-register computation for the write/read-back sequence.
  always_comb begin
    state_nxt    = state_r;
    awvalid_nxt  = awvalid_r;
    wvalid_nxt   = wvalid_r;
    wlast_nxt    = wlast_r;
    wdata_nxt    = wdata_r;
    wcnt_nxt     = wcnt_r;
    aw_done_nxt  = aw_done_r;
    w_done_nxt   = w_done_r;
    bready_nxt   = bready_r;
    arvalid_nxt  = arvalid_r;
    rready_nxt   = rready_r;
    rcnt_nxt     = rcnt_r;
    txn_done_nxt = 1'b0;
    error_nxt    = error_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt   = ST_WRITE;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          wlast_nxt   = (LAST_IDX == 5'd0);
          wdata_nxt   = {{(DW-1){1'b0}}, 1'b1};
          wcnt_nxt    = 5'd0;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          error_nxt   = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (aw_hs_s) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end else begin
          awvalid_nxt = awvalid_r;
        end
        if (w_hs_s) begin
          wcnt_nxt = wcnt_r + 5'd1;
          if (wlast_r) begin
            wvalid_nxt = 1'b0;
            wlast_nxt  = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            wdata_nxt = {{(DW-5){1'b0}}, wcnt_r + 5'd2};
            wlast_nxt = ((wcnt_r + 5'd1) == LAST_IDX);
          end
        end else begin
          wcnt_nxt = wcnt_r;
        end
        if ((aw_done_r | aw_hs_s) & (w_done_r | (w_hs_s & wlast_r))) begin
          state_nxt  = ST_WRESP;
          bready_nxt = 1'b1;
        end else begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRESP: begin
        if (b_hs_s) begin
          bready_nxt  = 1'b0;
          error_nxt   = error_r | (m_axi.M_AXI_BRESP != 2'b00);
          arvalid_nxt = 1'b1;
          rready_nxt  = 1'b1;
          rcnt_nxt    = 5'd0;
          state_nxt   = ST_READ;
        end else begin
          state_nxt = ST_WRESP;
        end
      end
      ST_READ: begin
        if (ar_hs_s) begin
          arvalid_nxt = 1'b0;
        end else begin
          arvalid_nxt = arvalid_r;
        end
        if (r_hs_s) begin
          error_nxt = error_r | beat_bad_s;
          if (m_axi.M_AXI_RLAST) begin
            state_nxt    = ST_DONE;
            rready_nxt   = 1'b0;
            arvalid_nxt  = 1'b0;
            txn_done_nxt = 1'b1;
          end else begin
            // Saturate so a runaway slave cannot wrap the index back onto valid beats.
            rcnt_nxt = (rcnt_r == 5'd31) ? rcnt_r : rcnt_r + 5'd1;
          end
        end else begin
          state_nxt = ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        wlast_nxt   = 1'b0;
        bready_nxt  = 1'b0;
        arvalid_nxt = 1'b0;
        rready_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously by reset.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_r    <= ST_IDLE;
      init_q_r   <= 1'b0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      wlast_r    <= 1'b0;
      wdata_r    <= {DW{1'b0}};
      wcnt_r     <= 5'd0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      bready_r   <= 1'b0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      rcnt_r     <= 5'd0;
      txn_done_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      init_q_r   <= INIT_AXI_TXN;
      awvalid_r  <= awvalid_nxt;
      wvalid_r   <= wvalid_nxt;
      wlast_r    <= wlast_nxt;
      wdata_r    <= wdata_nxt;
      wcnt_r     <= wcnt_nxt;
      aw_done_r  <= aw_done_nxt;
      w_done_r   <= w_done_nxt;
      bready_r   <= bready_nxt;
      arvalid_r  <= arvalid_nxt;
      rready_r   <= rready_nxt;
      rcnt_r     <= rcnt_nxt;
      txn_done_r <= txn_done_nxt;
      error_r    <= error_nxt;
    end
  end

  assign TXN_DONE             = txn_done_r;
  assign ERROR                = error_r;
  assign m_axi.M_AXI_AWID     = 1'b0;
  assign m_axi.M_AXI_AWADDR   = C_M_TARGET_BASE_ADDR;
  assign m_axi.M_AXI_AWLEN    = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi.M_AXI_AWSIZE   = 3'b010;
  assign m_axi.M_AXI_AWBURST  = 2'b01;
  assign m_axi.M_AXI_AWVALID  = awvalid_r;
  assign m_axi.M_AXI_WDATA    = wdata_r;
  assign m_axi.M_AXI_WSTRB    = 4'b1111;
  assign m_axi.M_AXI_WLAST    = wlast_r;
  assign m_axi.M_AXI_WVALID   = wvalid_r;
  assign m_axi.M_AXI_BREADY   = bready_r;
  assign m_axi.M_AXI_ARID     = 1'b0;
  assign m_axi.M_AXI_ARADDR   = C_M_TARGET_BASE_ADDR;
  assign m_axi.M_AXI_ARLEN    = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi.M_AXI_ARSIZE   = 3'b010;
  assign m_axi.M_AXI_ARBURST  = 2'b01;
  assign m_axi.M_AXI_ARVALID  = arvalid_r;
  assign m_axi.M_AXI_RREADY   = rready_r;

endmodule

// File: tb/tb_maxi_full_garin.sv
// Bench for maxi_full_garin: randomised memory slave plus a transaction-level
// model that predicts every W beat, handshake ordering, ERROR and TXN_DONE.
module tb_maxi_full_garin;
  localparam int         AW   = 6;
  localparam int         LEN  = 4;
  localparam logic [5:0] BASE = 6'h14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic txn_done, error;

  maxi_full_garin_if #(.C_M_AXI_ADDR_WIDTH(AW)) bus ();

  maxi_full_garin #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_BURST_LEN(LEN), .C_M_TARGET_BASE_ADDR(BASE)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(init),
    .TXN_DONE(txn_done), .ERROR(error), .m_axi(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // slave configuration
  int         stall_pct = 0;
  int         aw_delay = 0;
  int         corrupt_idx = -1;
  logic [1:0] bresp_cfg = 2'b00;
  logic [31:0] mem [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory slave ----------------
  initial begin
    int wb, rb, w_wait;
    bit aw_got, b_sent, ar_got, r_hs;
    logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0] s_wdata;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    wb = 0; rb = 0; w_wait = 0; aw_got = 0; b_sent = 0; ar_got = 0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0; s_wdata = 0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
    bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
    bus.M_AXI_RLAST = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wb = 0; rb = 0; w_wait = 0; aw_got = 0; b_sent = 0; ar_got = 0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RLAST = 0;
      end else begin
        // handshakes that completed on the posedge just past
        if (s_awvalid && bus.M_AXI_AWREADY) aw_got = 1;
        if (s_wvalid && bus.M_AXI_WREADY) begin
          if (wb < 16) mem[wb] = s_wdata;
          wb++;
        end
        if (bus.M_AXI_BVALID && s_bready) b_sent = 1;
        if (s_arvalid && bus.M_AXI_ARREADY) ar_got = 1;
        r_hs = bus.M_AXI_RVALID && s_rready;
        if (r_hs) rb++;
        if (b_sent && rb >= LEN) begin
          wb = 0; rb = 0; w_wait = 0; aw_got = 0; b_sent = 0; ar_got = 0;
        end
        if (wb >= LEN) w_wait++;
        // next drives
        if (aw_delay > 0) bus.M_AXI_AWREADY = (wb >= LEN) && (w_wait >= aw_delay);
        else bus.M_AXI_AWREADY = ($urandom_range(99) >= stall_pct);
        bus.M_AXI_WREADY  = ($urandom_range(99) >= stall_pct);
        bus.M_AXI_ARREADY = ($urandom_range(99) >= stall_pct);
        bus.M_AXI_BVALID  = aw_got && (wb >= LEN) && !b_sent;
        bus.M_AXI_BRESP   = bresp_cfg;
        if (bus.M_AXI_RVALID && !r_hs) begin
          // hold the presented beat until it is taken
        end else if (ar_got && rb < LEN && ($urandom_range(99) >= stall_pct)) begin
          bus.M_AXI_RVALID = 1;
          bus.M_AXI_RDATA  = (rb == corrupt_idx) ? 32'hFF : mem[rb];
          bus.M_AXI_RRESP  = 2'b00;
          bus.M_AXI_RLAST  = (rb == LEN - 1);
        end else begin
          bus.M_AXI_RVALID = 0;
          bus.M_AXI_RLAST  = 0;
        end
        s_awvalid = bus.M_AXI_AWVALID; s_wvalid = bus.M_AXI_WVALID; s_wdata = bus.M_AXI_WDATA;
        s_bready = bus.M_AXI_BREADY; s_arvalid = bus.M_AXI_ARVALID; s_rready = bus.M_AXI_RREADY;
      end
    end
  end

  // ---------------- transaction model and per-cycle compare ----------------
  initial begin
    bit busy, just_started, aw_seen, bdone, ar_seen, accept, exp_err, prev_init;
    int wb, rb;
    busy = 0; just_started = 0; aw_seen = 0; bdone = 0; ar_seen = 0; exp_err = 0;
    prev_init = 0; wb = 0; rb = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        check("reset_outputs", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST,
              bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY, txn_done, error,
              bus.M_AXI_WDATA}, 64'd0);
        busy = 0; just_started = 0; exp_err = 0; prev_init = 0;
      end else begin
        check("constants", {bus.M_AXI_AWID, bus.M_AXI_ARID, bus.M_AXI_AWADDR, bus.M_AXI_ARADDR,
              bus.M_AXI_AWLEN, bus.M_AXI_ARLEN, bus.M_AXI_AWSIZE, bus.M_AXI_ARSIZE,
              bus.M_AXI_AWBURST, bus.M_AXI_ARBURST, bus.M_AXI_WSTRB},
              {1'b0, 1'b0, BASE, BASE, 8'(LEN - 1), 8'(LEN - 1), 3'b010, 3'b010,
               2'b01, 2'b01, 4'hF});
        if (just_started) begin
          check("start_aw_w_error", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, error}, 3'b110);
          just_started = 0;
        end
        if (busy) begin
          if (!aw_seen) begin
            check("aw_held", bus.M_AXI_AWVALID, 1'b1);
            if (bus.M_AXI_AWREADY) aw_seen = 1;
          end else begin
            check("aw_dropped", bus.M_AXI_AWVALID, 1'b0);
          end
          if (wb >= LEN) begin
            check("w_after_last", bus.M_AXI_WVALID, 1'b0);
          end else begin
            check("w_no_bubble", bus.M_AXI_WVALID, 1'b1);
            check("wdata", bus.M_AXI_WDATA, 64'(wb + 1));
            check("wlast", bus.M_AXI_WLAST, (wb == LEN - 1));
            if (bus.M_AXI_WREADY) wb++;
          end
          if (!bdone) begin
            check("read_before_b", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 2'b00);
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
              bdone = 1;
              if (bus.M_AXI_BRESP != 2'b00) exp_err = 1;
            end
          end else if (!ar_seen) begin
            check("ar_held", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 2'b11);
            if (bus.M_AXI_ARREADY) ar_seen = 1;
          end else begin
            check("ar_dropped", bus.M_AXI_ARVALID, 1'b0);
          end
          if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
            if (bus.M_AXI_RDATA != 32'(rb + 1) || bus.M_AXI_RRESP != 2'b00 ||
                bus.M_AXI_RLAST != (rb == LEN - 1)) exp_err = 1;
            rb++;
          end
          if (txn_done) begin
            check("done_error", error, exp_err);
            check("done_wbeats", wb, LEN);
            check("done_rbeats", rb, LEN);
            done_cnt++;
          end
        end else begin
          check("idle_quiet", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST,
                bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY, txn_done}, 7'd0);
          check("idle_error_held", error, exp_err);
        end
        accept = init && !prev_init && !busy;
        if (busy && txn_done) busy = 0;
        if (accept) begin
          busy = 1; just_started = 1; aw_seen = 0; bdone = 0; ar_seen = 0;
          exp_err = 0; wb = 0; rb = 0;
        end
        prev_init = init;
      end
    end
  end

  // ---------------- scenario driver ----------------
  task automatic pulse();
    @(posedge clk); #1 init = 1'b1;
    @(posedge clk); #1 init = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    bit got;
    d0 = done_cnt; got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      if (done_cnt > d0) got = 1;
    end
    check({tag, "_timeout"}, got, 1'b1);
  endtask

  initial begin
    int d0;
    bit got;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // zero-wait pass, start level held high well beyond completion
    d0 = done_cnt;
    #1 init = 1'b1;
    wait_done("A", 200);
    repeat (30) @(posedge clk);
    #1 init = 1'b0;
    check("A_done_once", done_cnt - d0, 1);
    check("A_mem0", mem[0], 32'd1);
    check("A_mem1", mem[1], 32'd2);
    check("A_mem2", mem[2], 32'd3);
    check("A_mem3", mem[3], 32'd4);
    check("A_error", error, 1'b0);

    // late AWREADY and random stalls
    aw_delay = 3; stall_pct = 30; d0 = done_cnt;
    pulse();
    wait_done("B", 400);
    check("B_done_once", done_cnt - d0, 1);
    check("B_error", error, 1'b0);
    aw_delay = 0;

    // corrupted read beat 2, then a clean pass clears ERROR
    stall_pct = 20; corrupt_idx = 1;
    pulse();
    wait_done("C", 400);
    check("C_error_set", error, 1'b1);
    repeat (10) @(posedge clk);
    check("C_error_held", error, 1'b1);
    corrupt_idx = -1;
    pulse();
    #2 check("C_error_cleared", error, 1'b0);
    wait_done("C2", 400);
    check("C2_error", error, 1'b0);

    // SLVERR write response still reads back
    bresp_cfg = 2'b10; d0 = done_cnt;
    pulse();
    wait_done("D", 400);
    check("D_error", error, 1'b1);
    check("D_done_once", done_cnt - d0, 1);
    bresp_cfg = 2'b00;

    // reset while beat 2 is on the bus
    stall_pct = 0;
    pulse();
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.M_AXI_WVALID && bus.M_AXI_WDATA == 32'd2) got = 1;
    end
    check("E_beat2_seen", got, 1'b1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1 check("E_async_clear", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST,
             bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY, txn_done, error}, 8'd0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("E_no_done", done_cnt - d0, 0);
    pulse();
    wait_done("E2", 200);
    check("E2_done_once", done_cnt - d0, 1);
    check("E2_error", error, 1'b0);

    // second start edge during READ is ignored
    stall_pct = 40; d0 = done_cnt;
    pulse();
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.M_AXI_RREADY) got = 1;
    end
    check("F_read_reached", got, 1'b1);
    pulse();
    wait_done("F", 400);
    repeat (40) @(posedge clk);
    check("F_done_once", done_cnt - d0, 1);

    // random sweep
    for (int k = 0; k < 8; k++) begin
      stall_pct = $urandom_range(0, 50);
      aw_delay = ($urandom_range(0, 1) == 1) ? 3 : 0;
      d0 = done_cnt;
      pulse();
      wait_done("R", 600);
      check("R_done_once", done_cnt - d0, 1);
      check("R_error", error, 1'b0);
      repeat ($urandom_range(1, 5)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/maxi_full_garin.md
MAXI_FULL_GARIN -- requirements
Module: maxi_full_garin

Interface
REQ-001 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 6, byte-address width.
REQ-002 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 The block SHALL have parameter C_M_AXI_BURST_LEN, default 4, beats per burst, legal range 1..16.
REQ-004 The block SHALL have parameter C_M_TARGET_BASE_ADDR, default 0, burst start address.
REQ-005 M_AXI_ACLK  input  1  sole clock, all logic on rising edge.
REQ-006 M_AXI_ARESETN  input  1  asynchronous active-low reset.
REQ-007 INIT_AXI_TXN  input  1  start request, rising-edge detected.
REQ-008 TXN_DONE  output  1  one-cycle pulse at end of write+read-back.
REQ-009 ERROR  output  1  sticky error flag, cleared on next accepted start.
REQ-010 M_AXI_AWID/ARID  output  1  constant 0.
REQ-011 M_AXI_AWADDR/ARADDR  output  C_M_AXI_ADDR_WIDTH  equal to C_M_TARGET_BASE_ADDR.
REQ-012 M_AXI_AWLEN/ARLEN  output  8  constant C_M_AXI_BURST_LEN-1.
REQ-013 M_AXI_AWSIZE/ARSIZE  output  3  constant 3'b010 (4 bytes).
REQ-014 M_AXI_AWBURST/ARBURST  output  2  constant 2'b01 (INCR).
REQ-015 M_AXI_AWVALID, M_AXI_ARVALID  output  1  address valid; M_AXI_AWREADY, M_AXI_ARREADY  input  1.
REQ-016 M_AXI_WDATA  output  32  write data; M_AXI_WSTRB  output  4  constant 4'b1111.
REQ-017 M_AXI_WLAST, M_AXI_WVALID  output  1; M_AXI_WREADY  input  1.
REQ-018 M_AXI_BRESP  input  2; M_AXI_BVALID  input  1; M_AXI_BREADY  output  1.
REQ-019 M_AXI_RDATA  input  32; M_AXI_RRESP  input  2; M_AXI_RLAST, M_AXI_RVALID  input  1; M_AXI_RREADY  output  1.

Function
REQ-020 The FSM SHALL have states IDLE, WRITE, WRESP, READ, DONE; IDLE->WRITE on INIT_AXI_TXN rising edge only in IDLE, and that edge clears ERROR.
REQ-021 On the IDLE->WRITE transition, AWVALID and WVALID SHALL both rise on the next cycle; AWVALID holds until the AWREADY handshake, then drops the following cycle.
REQ-022 Each W beat SHALL transfer on WVALID&WREADY; the beat counter increments per handshake; WVALID remains high between beats while beats remain (no bubbles).
REQ-023 Beat i (0-based) SHALL carry WDATA = i+1; WLAST SHALL be high exactly on beat C_M_AXI_BURST_LEN-1; WVALID and WLAST drop the cycle after the last handshake.
REQ-024 WRITE->WRESP once both the AW and last-W handshakes have completed, in either order or simultaneously.
REQ-025 In WRESP, BREADY SHALL be high; on BVALID&BREADY, BREADY drops next cycle, ERROR is set if BRESP!=2'b00, and the FSM goes to READ.
REQ-026 On entry to READ, ARVALID SHALL rise and hold until the ARREADY handshake; RREADY SHALL be high throughout READ.
REQ-027 Each R handshake SHALL compare RDATA with beat index+1; a mismatch or RRESP!=2'b00 sets ERROR.
REQ-028 The R handshake with RLAST=1 SHALL end READ and go to DONE; RLAST on the wrong beat count sets ERROR.
REQ-029 DONE SHALL assert TXN_DONE for exactly one cycle, then return to IDLE.
REQ-030 An INIT_AXI_TXN rising edge outside IDLE SHALL be ignored; a level held high SHALL NOT retrigger.
REQ-031 Beat counters SHALL be 5 bits wide, cleared on each address phase, and SHALL never wrap within a burst.

Reset
REQ-032 While M_AXI_ARESETN=0, asynchronously: FSM=IDLE; all VALID/READY/WLAST outputs, TXN_DONE, ERROR, and counters=0; WDATA=0; the start-edge register is cleared.
REQ-033 Reset mid-burst SHALL drop all valids immediately, with no completion pulse; operation resumes only on a new start edge after release.

Verification
REQ-034 Zero-wait memory slave, LEN=4, start pulse -> WDATA 1,2,3,4 with WLAST on beat 4, read back matches, TXN_DONE pulses once, ERROR=0.
REQ-035 Slave delays AWREADY 3 cycles after W completes, inserts random WREADY/RVALID stalls -> same data, no duplicated or dropped beats, ERROR=0.
REQ-036 Slave corrupts read beat 2 (returns 0xFF) -> ERROR=1 after DONE, held; next start edge clears it, and a clean pass leaves ERROR=0.
REQ-037 BRESP=2'b10 -> read still performed, ERROR=1, TXN_DONE pulses.
REQ-038 Reset asserted during W beat 2 -> all outputs 0 the same cycle; no TXN_DONE; a new start gives a normal full transaction.
REQ-039 Second start edge during READ -> ignored, exactly one TXN_DONE produced.
